// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite slave bus bundle with master/slave views
interface ahb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite slave memory; wait states compiled in by AHB_SLV_WAIT_EN
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            hclk,
  input logic            hresetn,
  ahb_slave_mem_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BS    = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AQ_W  = BS + IDX_W;

`ifdef AHB_SLV_WAIT_EN
  localparam bit WAIT_ON = (WAIT_CYCLES != 0);
`else
  localparam bit WAIT_ON = 1'b0;
`endif
  // Counter runs WAIT_CYCLES-1 down to 0, giving WAIT_CYCLES stalled cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [AQ_W-1:0]       addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  ready;
  logic                  accept;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [2:0]            low_mask;
  logic [BYTES-1:0]      byte_en;
  logic [IDX_W-1:0]      idx_q;
  logic [BS-1:0]         off_q;
  logic                  unused_bits;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign ready         = !((state == S_WAIT) || (state == S_ERR1));
  assign bus.hreadyout = ready;
  assign bus.hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
  assign idx_q         = addr_q[AQ_W-1:BS];
  assign off_q         = addr_q[BS-1:0];
  assign unused_bits   = ^{bus.hburst, bus.hprot, bus.htrans[0]};

  // Address-phase decode: acceptance only while we are ready, plus legality of the request.
  always_comb begin
    word_idx = bus.haddr >> BS;
    low_mask = ~(3'b111 << bus.hsize);
    illegal  = (word_idx >= ADDR_WIDTH'(MEM_DEPTH))
            || (bus.hsize > 3'(BS))
            || (|(bus.haddr[2:0] & low_mask));
    accept   = ready && bus.hsel && bus.hready && bus.htrans[1];
  end

  // State and wait-counter registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state: finish the current data phase, then let a newly accepted transfer override it.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_DATA, S_ERR2: state_nxt = S_IDLE;
      S_ERR1:         state_nxt = S_ERR2;
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_DATA;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      default: ;
    endcase
    if (accept) begin
      if (illegal) begin
        state_nxt = S_ERR1;
      end else if (WAIT_ON) begin
        state_nxt    = S_WAIT;
        wait_cnt_nxt = WAIT_LOAD;
      end else begin
        state_nxt = S_DATA;
      end
    end
  end

  // Capture the address-phase controls for use in the following data phase.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (accept) begin
      addr_q  <= bus.haddr[AQ_W-1:0];
      write_q <= bus.hwrite;
      size_q  <= bus.hsize;
    end
  end

  // Little-endian byte lanes covered by the registered offset and size.
  always_comb begin
    byte_en = '0;
    for (int k = 0; k < BYTES; k++) begin
      if ((k >= int'(off_q)) && (k < int'(off_q) + (1 << size_q))) byte_en[k] = 1'b1;
    end
  end

  // Memory write at the end of a write data phase; contents survive reset.
  always_ff @(posedge hclk) begin
    if (hresetn && (state == S_DATA) && write_q) begin
      for (int k = 0; k < BYTES; k++) begin
        if (byte_en[k]) mem[idx_q][8*k +: 8] <= bus.hwdata[8*k +: 8];
      end
    end
  end

  // Asynchronous read so a write completed on the previous edge is seen immediately.
  always_comb begin
    bus.hrdata = '0;
    if ((state == S_DATA) && !write_q) bus.hrdata = mem[idx_q];
  end

endmodule
